// File: rtl/driver_reg_master.sv
// Host-side initiator for the driver control register port: programs thresholds,
// streams vector addresses into the address FIFO under level-polled credit, then ends or aborts.
module driver_reg_master #(
  parameter int FIFO_DEPTH = 1024,
  parameter int MARGIN     = 4,
  parameter int RD_WAIT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] cfg_athr,
  input  logic [15:0] cfg_vthr,
  input  logic        cfg_swap,
  input  logic [31:0] s_addr,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_awaddr,
  output logic        m_wr,
  output logic [31:0] m_wdata,
  output logic [31:0] m_araddr,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] words_sent
);

  // Handshake: a word moves only in a cycle where s_valid and s_ready are both high;
  // s_ready is high only in FEED with credit left and no abort pending.

  typedef enum logic [3:0] {
    IDLE, WR_ATHR, WR_VTHR, POLL_LVL, POLL_STAT, FEED,
    WR_SHORT, WR_RUN, DRAIN_CHK, WR_END, WR_ABORT
  } state_t;

  localparam logic [31:0] CAP     = 32'(FIFO_DEPTH - MARGIN);
  localparam logic [7:0]  RD_LAST = 8'(RD_WAIT - 1);

  localparam logic [31:0] A_FIFO = 32'h000;
  localparam logic [31:0] A_CTRL = 32'h004;
  localparam logic [31:0] A_ATHR = 32'h008;
  localparam logic [31:0] A_VTHR = 32'h00C;
  localparam logic [31:0] A_STAT = 32'h100;
  localparam logic [31:0] A_LVL  = 32'h108;

  state_t      state, state_next;
  logic [7:0]  rd_cnt;
  logic [31:0] credit;
  logic [31:0] ws;
  logic        run_sent, last_taken, err_q;
  logic [15:0] athr_q, vthr_q;
  logic        swap_q;

  logic        rd_done, abort_hit, accept, set_err, done_c, rdy_c, wr_c;
  logic [31:0] awaddr_c, wdata_c, araddr_c;
  logic [31:0] ws_next, lvl32, credit_new;
  logic        unused_rdata;

  assign unused_rdata = ^{m_rdata[31], m_rdata[29:16]};
  assign rd_done      = (rd_cnt == RD_LAST);
  assign abort_hit    = abort && (state != IDLE) && (state != WR_ABORT);
  assign ws_next      = ws + 32'd1;
  assign lvl32        = {16'h0, m_rdata[15:0]};
  assign credit_new   = (lvl32 >= CAP) ? 32'd0 : (CAP - lvl32);

  always_comb begin
    state_next = state;
    wr_c       = 1'b0;
    awaddr_c   = '0;
    wdata_c    = '0;
    araddr_c   = '0;
    rdy_c      = 1'b0;
    accept     = 1'b0;
    done_c     = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: if (start) state_next = WR_ATHR;
      WR_ATHR: begin
        wr_c = 1'b1; awaddr_c = A_ATHR; wdata_c = {16'h0, athr_q};
        state_next = WR_VTHR;
      end
      WR_VTHR: begin
        wr_c = 1'b1; awaddr_c = A_VTHR; wdata_c = {16'h0, vthr_q};
        state_next = POLL_LVL;
      end
      POLL_LVL: begin
        araddr_c = A_LVL;
        if (rd_done) state_next = POLL_STAT;
      end
      POLL_STAT: begin
        araddr_c = A_STAT;
        if (rd_done) begin
          if (m_rdata[30]) begin
            set_err    = 1'b1;
            state_next = WR_ABORT;
          end else if (last_taken) state_next = DRAIN_CHK;
          else if (credit == 32'd0) state_next = POLL_LVL;
          else state_next = FEED;
        end
      end
      FEED: begin
        rdy_c = (credit != 32'd0);
        if (credit == 32'd0) state_next = POLL_LVL;
        else if (s_valid) begin
          accept = 1'b1; wr_c = 1'b1; awaddr_c = A_FIFO; wdata_c = s_addr;
          if (s_last) begin
            if (!run_sent) state_next = (ws_next < {16'h0, athr_q}) ? WR_SHORT : WR_RUN;
            else state_next = POLL_LVL;
          end else if (!run_sent && ws_next >= {16'h0, athr_q}) state_next = WR_RUN;
          else if (credit == 32'd1) state_next = POLL_LVL;
        end
      end
      WR_SHORT: begin
        wr_c = 1'b1; awaddr_c = A_ATHR; wdata_c = ws;
        state_next = WR_RUN;
      end
      WR_RUN: begin
        wr_c = 1'b1; awaddr_c = A_CTRL; wdata_c = {26'h0, swap_q, 5'b00001};
        state_next = POLL_LVL;
      end
      DRAIN_CHK: begin
        araddr_c = A_LVL;
        if (rd_done) state_next = (m_rdata[15:0] == 16'h0) ? WR_END : POLL_STAT;
      end
      WR_END: begin
        wr_c = 1'b1; awaddr_c = A_CTRL; wdata_c = {26'h0, swap_q, 5'b00010};
        done_c = 1'b1;
        state_next = IDLE;
      end
      WR_ABORT: begin
        wr_c = 1'b1; awaddr_c = A_CTRL; wdata_c = 32'h4;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort pre-empts whatever this cycle would do, so no 0x004 write lands next to the abort write.
    if (abort_hit) begin
      state_next = WR_ABORT;
      wr_c = 1'b0; rdy_c = 1'b0; accept = 1'b0; done_c = 1'b0; set_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      credit     <= '0;
      ws         <= '0;
      run_sent   <= 1'b0;
      last_taken <= 1'b0;
      err_q      <= 1'b0;
      athr_q     <= '0;
      vthr_q     <= '0;
      swap_q     <= 1'b0;
    end else begin
      state  <= state_next;
      rd_cnt <= (state_next != state) ? 8'd0 : rd_cnt + 8'd1;
      if (state == IDLE && start) begin
        err_q      <= 1'b0;
        ws         <= '0;
        run_sent   <= 1'b0;
        last_taken <= 1'b0;
        athr_q     <= cfg_athr;
        vthr_q     <= cfg_vthr;
        swap_q     <= cfg_swap;
      end
      if (set_err) err_q <= 1'b1;
      if (state == POLL_LVL && rd_done && !abort_hit) credit <= credit_new;
      if (accept) begin
        ws     <= ws_next;
        credit <= credit - 32'd1;
        if (s_last) last_taken <= 1'b1;
      end
      if (state == WR_RUN && !abort_hit) run_sent <= 1'b1;
    end
  end

  // Outputs are forced low while reset is held so nothing reaches the bus before the reset edge.
  assign s_ready    = reset & rdy_c;
  assign m_wr       = reset & wr_c;
  assign m_awaddr   = reset ? awaddr_c : 32'h0;
  assign m_wdata    = reset ? wdata_c : 32'h0;
  assign m_araddr   = reset ? araddr_c : 32'h0;
  assign busy       = reset & (state != IDLE);
  assign done       = reset & done_c;
  assign error      = reset & err_q;
  assign words_sent = reset ? ws : 32'h0;

endmodule

// File: doc/driver_reg_master.md
Name: driver_reg_master

Overview:
- Host-side initiator for the driver control register interface. It is the other end of the slave register port.
- It takes a stream of vector addresses from an upstream source and pushes them into the address FIFO through register 0x000, with flow control from polled FIFO levels.
- It programs the address and vector thresholds, starts the program, monitors status for errors, and ends or aborts the program.
- It sits between the host command path and the driver control slave.

Parameters:
- FIFO_DEPTH, 1024, address FIFO capacity in words.
- MARGIN, 4, headroom kept free in the FIFO to cover level-report lag.
- RD_WAIT, 2, cycles that m_araddr is held before m_rdata is sampled.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  1  one-cycle pulse; begins a program from IDLE
- abort  in  1  one-cycle pulse; aborts the active sequence
- cfg_athr  in  16  address FIFO threshold to program
- cfg_vthr  in  16  vector FIFO threshold to program
- cfg_swap  in  1  vector_byte_swap bit for the control word
- s_addr  in  32  upstream address word
- s_last  in  1  marks the final word
- s_valid  in  1  upstream word valid
- s_ready  out  1  upstream word accepted
- m_awaddr  out  32  write address to slave
- m_wr  out  1  write strobe, one cycle per write
- m_wdata  out  32  write data to slave
- m_araddr  out  32  read address to slave
- m_rdata  in  32  slave registered read data
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on normal completion
- error  out  1  sticky program_error seen; cleared by the next start
- words_sent  out  32  addresses written in the current program

Behaviour:
- Reset: reset, synchronous, active-low; clock clk. While reset is low, all outputs are 0, m_awaddr and m_araddr are 0, and the state is IDLE. Asserting reset mid-sequence abandons the sequence and performs no bus write.
- Write transaction: one cycle with m_wr=1 and m_awaddr/m_wdata valid. Writes are never issued back-to-back to 0x004.
- Read transaction: drive m_araddr and hold it RD_WAIT cycles, then sample m_rdata. m_rd does not exist because the slave ignores it.
- States:
  - IDLE: on start, clear error, clear words_sent and the run_sent flag, go to WR_ATHR.
  - WR_ATHR: write 0x008 = {16'h0, cfg_athr}.
  - WR_VTHR: write 0x00C = {16'h0, cfg_vthr}.
  - POLL_LVL: read 0x108. Set credit = FIFO_DEPTH - MARGIN - level[15:0], saturating at 0.
  - POLL_STAT: read 0x100. If bit30 (program_error) is set: set error, go to WR_ABORT. Otherwise, if last_taken is set, go to DRAIN_CHK; if credit = 0, go to POLL_LVL; else go to FEED.
  - FEED: s_ready=1. Each cycle with s_valid & s_ready: write 0x000 = s_addr, increment words_sent, decrement credit. s_ready drops in the cycle credit reaches 0, and the state returns to POLL_LVL.
    - If !run_sent and words_sent reaches cfg_athr: leave FEED for WR_RUN after that write.
    - On s_last accepted: set last_taken. If !run_sent and words_sent < cfg_athr (after this word), go to WR_SHORT; otherwise, if !run_sent, go to WR_RUN; otherwise go to POLL_LVL.
  - WR_SHORT: write 0x008 = words_sent so the slave can start a short program, then go to WR_RUN.
  - WR_RUN: write 0x004 = {cfg_swap at bit5, run bit0 = 1}, set run_sent. Go to POLL_LVL.
  - DRAIN_CHK: read 0x108. If level = 0, go to WR_END; else go to POLL_STAT.
  - WR_END: write 0x004 = {cfg_swap bit5, end bit1 = 1, run bit0 = 0}. Pulse done. Go to IDLE.
  - WR_ABORT: write 0x004 = {abort bit2 = 1}. Go to IDLE. done is not pulsed.
- abort pulse in any non-IDLE state: go to WR_ABORT on the next cycle. An abort arriving during a read discards that read. An abort arriving in IDLE is ignored.
- A start pulse arriving while busy is ignored.
- s_valid=1 with s_ready=0 never consumes a word. Words are never dropped or duplicated.
- Credit is recomputed only from a fresh level read, never carried across polls.
- words_sent wraps modulo 2^32.
- A zero-length program (s_last is never seen before abort) simply aborts.
- cfg_athr=0: run_sent is written after the first word.

Test Plan:
- Reset low 3 cycles during FEED, then high → all outputs 0, no m_wr during or after reset, state IDLE.
- start, cfg_athr=8, cfg_vthr=100, 20 words with s_last on the 20th, slave level model drains 1 word per 4 cycles → writes in order: 0x008=8, 0x00C=100, 8 × 0x000, 0x004=0x1, 12 × 0x000; after level reaches 0, 0x004=0x2; done pulse; words_sent=20.
- cfg_athr=16, only 5 words with s_last → 0x008 rewritten to 5 before 0x004 run; done after drain.
- Level model reports 1019 (FIFO_DEPTH=1024) → credit=1: exactly one 0x000 write, then re-poll; level 1020 → s_ready stays 0.
- Status read returns bit30=1 mid-feed → error=1, 0x004=0x4 written, IDLE, no done pulse.
- abort pulse during a read hold → next cycle WR_ABORT write 0x004=0x4; any later start clears error and restarts with the 0x008 write.
